// File: rtl/rv32_pkg.sv
// Shared RV32 writeback types: register index and the queued result record.
package rv32_pkg;

   localparam int XLEN = 32;

   typedef logic [4:0] reg_idx_t;

   typedef struct packed {
      reg_idx_t          rd;
      logic [XLEN-1:0]   data;
   } wb_req_t;

endpackage

// File: rtl/wb_fifo.sv
// In-order result queue; push and pop may coincide, even when full.
module wb_fifo
   import rv32_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  logic                   pop,
   input  wb_req_t                din,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count,
   output wb_req_t                head
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   wb_req_t       mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign empty   = (count == '0);
   assign full    = (count == DEPTH_C);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

   // Storage carries no reset; count alone defines which entries are live.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/wb_arbiter.sv
// Register-file writeback arbiter: load > queued ALU > bypassed ALU, plus
// the per-register busy scoreboard used by the hazard logic.
module wb_arbiter #(
   parameter int XLEN  = rv32_pkg::XLEN,
   parameter int DEPTH = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            iss_valid,
   input  logic [4:0]      iss_rd,
   output logic [31:0]     busy,
   input  logic            alu_valid,
   output logic            alu_ready,
   input  logic [4:0]      alu_rd,
   input  logic [XLEN-1:0] alu_data,
   input  logic            ld_valid,
   input  logic [4:0]      ld_rd,
   input  logic [XLEN-1:0] ld_data,
   output logic            w_en,
   output logic [4:0]      w_rd,
   output logic [XLEN-1:0] w_data
);

   localparam int CW = $clog2(DEPTH) + 1;

   rv32_pkg::wb_req_t head;
   rv32_pkg::wb_req_t alu_req;
   logic              push;
   logic              pop;
   logic              full;
   logic              empty;
   logic [CW-1:0]     count;
   logic              alu_live;
   logic              ld_live;
   logic              sel_en;
   logic [4:0]        sel_rd;
   logic [XLEN-1:0]   sel_data;
   logic [31:0]       busy_nxt;

   assign alu_ready = !rst && !full;
   // x0 results are consumed here and never compete for the write port.
   assign alu_live  = alu_valid && alu_ready && (alu_rd != 5'd0);
   assign ld_live   = ld_valid && (ld_rd != 5'd0);
   assign alu_req   = '{rd: alu_rd, data: alu_data};

   wb_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .din   (alu_req),
      .full  (full),
      .empty (empty),
      .count (count),
      .head  (head)
   );

   always_comb begin
      sel_en   = 1'b0;
      sel_rd   = w_rd;
      sel_data = w_data;
      pop      = 1'b0;
      if (ld_live) begin
         sel_en   = 1'b1;
         sel_rd   = ld_rd;
         sel_data = ld_data;
      end else if (!empty) begin
         pop      = 1'b1;
         sel_en   = 1'b1;
         sel_rd   = head.rd;
         sel_data = head.data;
      end else if (alu_live) begin
         sel_en   = 1'b1;
         sel_rd   = alu_rd;
         sel_data = alu_data;
      end
      push = alu_live && (ld_live || !empty);
   end

   always_comb begin
      busy_nxt = busy;
      if (w_en) busy_nxt[w_rd] = 1'b0;
      if (iss_valid && (iss_rd != 5'd0)) busy_nxt[iss_rd] = 1'b1;
      busy_nxt[0] = 1'b0;
   end

   // Output register stage: write port and scoreboard update together.
   always_ff @(posedge clk) begin
      if (rst) begin
         w_en   <= 1'b0;
         w_rd   <= '0;
         w_data <= '0;
         busy   <= '0;
      end else begin
         w_en   <= sel_en;
         w_rd   <= sel_rd;
         w_data <= sel_data;
         busy   <= busy_nxt;
      end
   end

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios plus a random run against a
// pending-results list model.
module tb_wb_arbiter;

   localparam int XLEN  = 32;
   localparam int DEPTH = 2;

   typedef struct packed {
      logic [4:0]  rd;
      logic [31:0] data;
   } ent_t;

   logic            clk;
   logic            rst;
   logic            iss_valid;
   logic [4:0]      iss_rd;
   logic [31:0]     busy;
   logic            alu_valid;
   logic            alu_ready;
   logic [4:0]      alu_rd;
   logic [XLEN-1:0] alu_data;
   logic            ld_valid;
   logic [4:0]      ld_rd;
   logic [XLEN-1:0] ld_data;
   logic            w_en;
   logic [4:0]      w_rd;
   logic [XLEN-1:0] w_data;

   int n_tests = 0;
   int n_fail  = 0;

   // model state
   ent_t        req_q [$];
   logic        m_w_en;
   logic [4:0]  m_w_rd;
   logic [31:0] m_w_data;
   logic [31:0] m_busy;

   wb_arbiter #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .iss_valid (iss_valid),
      .iss_rd    (iss_rd),
      .busy      (busy),
      .alu_valid (alu_valid),
      .alu_ready (alu_ready),
      .alu_rd    (alu_rd),
      .alu_data  (alu_data),
      .ld_valid  (ld_valid),
      .ld_rd     (ld_rd),
      .ld_data   (ld_data),
      .w_en      (w_en),
      .w_rd      (w_rd),
      .w_data    (w_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic idle();
      iss_valid = 0; iss_rd = 0;
      alu_valid = 0; alu_rd = 0; alu_data = 0;
      ld_valid = 0;  ld_rd = 0;  ld_data = 0;
   endtask

   task automatic rand_inputs();
      iss_valid = ($urandom_range(0, 3) == 0);
      iss_rd    = 5'($urandom_range(0, 31));
      alu_valid = ($urandom_range(0, 9) < 6);
      alu_rd    = 5'($urandom_range(0, 7));
      alu_data  = $urandom;
      ld_valid  = ($urandom_range(0, 9) < 3);
      ld_rd     = 5'($urandom_range(0, 7));
      ld_data   = $urandom;
   endtask

   function automatic logic model_ready();
      return !rst && (req_q.size() < DEPTH);
   endfunction

   // Advance model and DUT one clock; all still-pending results form one
   // ordered list with the load at its front and a new ALU result at its back.
   task automatic tick();
      ent_t        pend [$];
      ent_t        r;
      logic [31:0] nb;
      logic        acc;
      acc = alu_valid && model_ready();
      nb  = m_busy;
      if (m_w_en) nb[m_w_rd] = 1'b0;
      if (iss_valid && iss_rd != 0) nb[iss_rd] = 1'b1;
      if (rst) begin
         req_q.delete();
         m_w_en = 0; m_w_rd = 0; m_w_data = 0; nb = 0;
      end else begin
         pend = req_q;
         if (ld_valid && ld_rd != 0) pend.push_front('{rd: ld_rd, data: ld_data});
         if (acc && alu_rd != 0) pend.push_back('{rd: alu_rd, data: alu_data});
         if (pend.size() > 0) begin
            r = pend.pop_front();
            m_w_en = 1; m_w_rd = r.rd; m_w_data = r.data;
         end else begin
            m_w_en = 0;
         end
         req_q = pend;
      end
      m_busy = nb;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1;
      for (int i = 0; i < 2; i++) begin
         rand_inputs();
         #1;
         n_tests++;
         if (alu_ready !== 1'b0) begin
            n_fail++; $display("FAIL reset_ready: got %b want 0", alu_ready);
         end
         tick();
         n_tests++;
         if (w_en !== 1'b0 || w_rd !== 5'd0 || w_data !== 32'd0 || busy !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: w_en=%b w_rd=%0d w_data=%h busy=%h want all 0",
                     w_en, w_rd, w_data, busy);
         end
      end
      rst = 0;
      idle();
      #1;
      n_tests++;
      if (alu_ready !== 1'b1 || busy !== 32'd0) begin
         n_fail++; $display("FAIL post_reset: ready=%b busy=%h want 1 / 0", alu_ready, busy);
      end
   endtask

   task automatic test_bypass();
      idle();
      alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF;
      tick();
      idle();
      n_tests++;
      if (w_en !== 1'b1 || w_rd !== 5'd5 || w_data !== 32'hDEADBEEF) begin
         n_fail++;
         $display("FAIL bypass: w_en=%b w_rd=%0d w_data=%h want 1/5/deadbeef", w_en, w_rd, w_data);
      end
      tick();
      n_tests++;
      if (w_en !== 1'b0 || w_rd !== 5'd5 || w_data !== 32'hDEADBEEF) begin
         n_fail++;
         $display("FAIL bypass_hold: w_en=%b w_rd=%0d w_data=%h want 0/5/deadbeef", w_en, w_rd, w_data);
      end
   endtask

   task automatic test_collision();
      idle();
      ld_valid = 1; ld_rd = 3; ld_data = 32'h11;
      alu_valid = 1; alu_rd = 3; alu_data = 32'h22;
      tick();
      idle();
      n_tests++;
      if (w_en !== 1'b1 || w_rd !== 5'd3 || w_data !== 32'h11) begin
         n_fail++; $display("FAIL collision_first: w_en=%b w_rd=%0d w_data=%h want 1/3/11", w_en, w_rd, w_data);
      end
      tick();
      n_tests++;
      if (w_en !== 1'b1 || w_rd !== 5'd3 || w_data !== 32'h22) begin
         n_fail++; $display("FAIL collision_second: w_en=%b w_rd=%0d w_data=%h want 1/3/22", w_en, w_rd, w_data);
      end
      tick();
      n_tests++;
      if (w_en !== 1'b0) begin
         n_fail++; $display("FAIL collision_done: w_en=%b want 0", w_en);
      end
   endtask

   task automatic test_full_queue();
      logic [31:0] exp_data [5];
      logic [4:0]  exp_rd   [5];
      logic        exp_rdy  [3];
      exp_rdy = '{1'b1, 1'b1, 1'b0};
      for (int i = 0; i < 3; i++) begin
         exp_rd[i]   = 5'(10 + i);
         exp_data[i] = 32'hA000_0000 + 32'(i);
      end
      for (int i = 0; i < 2; i++) begin
         exp_rd[3+i]   = 5'(20 + i);
         exp_data[3+i] = 32'hB000_0000 + 32'(i);
      end
      for (int i = 0; i < 3; i++) begin
         idle();
         ld_valid = 1; ld_rd = 5'(10 + i); ld_data = 32'hA000_0000 + 32'(i);
         alu_valid = 1; alu_rd = 5'(20 + i); alu_data = 32'hB000_0000 + 32'(i);
         #1;
         n_tests++;
         if (alu_ready !== exp_rdy[i]) begin
            n_fail++; $display("FAIL full_ready[%0d]: got %b want %b", i, alu_ready, exp_rdy[i]);
         end
         tick();
         n_tests++;
         if (w_en !== 1'b1 || w_rd !== exp_rd[i] || w_data !== exp_data[i]) begin
            n_fail++; $display("FAIL full_write[%0d]: w_en=%b w_rd=%0d w_data=%h want 1/%0d/%h",
                               i, w_en, w_rd, w_data, exp_rd[i], exp_data[i]);
         end
      end
      idle();
      for (int i = 3; i < 5; i++) begin
         tick();
         n_tests++;
         if (w_en !== 1'b1 || w_rd !== exp_rd[i] || w_data !== exp_data[i]) begin
            n_fail++; $display("FAIL full_drain[%0d]: w_en=%b w_rd=%0d w_data=%h want 1/%0d/%h",
                               i, w_en, w_rd, w_data, exp_rd[i], exp_data[i]);
         end
      end
      tick();
      n_tests++;
      if (w_en !== 1'b0 || alu_ready !== 1'b1) begin
         n_fail++; $display("FAIL full_empty: w_en=%b ready=%b want 0/1", w_en, alu_ready);
      end
   endtask

   task automatic test_x0();
      idle();
      alu_valid = 1; alu_rd = 0; alu_data = 32'hFFFFFFFF;
      #1;
      n_tests++;
      if (alu_ready !== 1'b1) begin
         n_fail++; $display("FAIL x0_accept: ready=%b want 1", alu_ready);
      end
      tick();
      idle();
      n_tests++;
      if (w_en !== 1'b0 || busy !== 32'd0) begin
         n_fail++; $display("FAIL x0_write: w_en=%b busy=%h want 0/0", w_en, busy);
      end
      tick();
      n_tests++;
      if (w_en !== 1'b0) begin
         n_fail++; $display("FAIL x0_later: w_en=%b want 0", w_en);
      end
   endtask

   task automatic test_scoreboard();
      idle();
      iss_valid = 1; iss_rd = 7;
      tick();
      idle();
      n_tests++;
      if (busy[7] !== 1'b1) begin
         n_fail++; $display("FAIL sb_set: busy[7]=%b want 1", busy[7]);
      end
      tick();
      alu_valid = 1; alu_rd = 7; alu_data = 32'h77;
      tick();
      idle();
      iss_valid = 1; iss_rd = 7;
      n_tests++;
      if (w_en !== 1'b1 || w_rd !== 5'd7 || busy[7] !== 1'b1) begin
         n_fail++; $display("FAIL sb_write: w_en=%b w_rd=%0d busy[7]=%b want 1/7/1", w_en, w_rd, busy[7]);
      end
      tick();
      idle();
      n_tests++;
      if (busy[7] !== 1'b1) begin
         n_fail++; $display("FAIL sb_set_wins: busy[7]=%b want 1", busy[7]);
      end
      alu_valid = 1; alu_rd = 7; alu_data = 32'h78;
      tick();
      idle();
      tick();
      n_tests++;
      if (busy[7] !== 1'b0 || busy[0] !== 1'b0) begin
         n_fail++; $display("FAIL sb_clear: busy[7]=%b busy[0]=%b want 0/0", busy[7], busy[0]);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         rand_inputs();
         rst = ($urandom_range(0, 99) == 0);
         #1;
         n_tests++;
         if (alu_ready !== model_ready()) begin
            n_fail++; $display("FAIL rand_ready[%0d]: got %b want %b", i, alu_ready, model_ready());
         end
         tick();
         n_tests++;
         if (w_en !== m_w_en || w_rd !== m_w_rd || w_data !== m_w_data || busy !== m_busy) begin
            n_fail++;
            $display("FAIL rand_out[%0d]: got en=%b rd=%0d data=%h busy=%h want en=%b rd=%0d data=%h busy=%h",
                     i, w_en, w_rd, w_data, busy, m_w_en, m_w_rd, m_w_data, m_busy);
         end
      end
      rst = 0;
      idle();
      for (int i = 0; i < 4; i++) tick();
      n_tests++;
      if (w_en !== 1'b0 || busy !== m_busy || alu_ready !== 1'b1) begin
         n_fail++; $display("FAIL rand_drain: en=%b busy=%h ready=%b want 0/%h/1", w_en, busy, alu_ready, m_busy);
      end
   endtask

   initial begin
      req_q.delete();
      m_w_en = 0; m_w_rd = 0; m_w_data = 0; m_busy = 0;
      rst = 1;
      idle();
      #1;
      test_reset();
      test_bypass();
      test_collision();
      test_full_queue();
      test_x0();
      test_scoreboard();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
